// File: rtl/rx_bit_decoder.sv
// ---------------------------------------------------------------------------
// rx_bit_decoder
//
// USB receive bit-level decoder. On every sample strobe it NRZI-decodes the
// synchronized D+/D- pair, strips stuffed zeros, detects EOP (two SE0
// samples) and assembles data bytes LSB-first.
//
// Optional feature macro: RX_STUFF_ERR_EN
//   defined   : a decoded 1 in the stuffed-bit slot pulses stuff_err
//   undefined : stuff_err is tied low and no error logic is built
//
// Parameters:
//   ONES_LIMIT    consecutive decoded ones after which the next bit is stuffed
//
// Ports:
//   clk           system clock
//   n_rst         asynchronous active-low reset
//   d_plus_sync   synchronized D+
//   d_minus_sync  synchronized D-
//   shift         one-clk sample strobe from the RX timer
//   enable        packet reception active (low aborts like clear)
//   clear         synchronous restart at start of packet
//   rx_byte       last completed byte, held until the next one completes
//   byte_ready    one-clk pulse: rx_byte just updated
//   stuff_bit     one-clk pulse: the next sampled bit is a stuffed bit
//   eop           one-clk pulse: end of packet detected
//   stuff_err     one-clk pulse: stuffed bit decoded as 1
// ---------------------------------------------------------------------------
module rx_bit_decoder #(
    parameter int ONES_LIMIT = 6
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       d_plus_sync,
    input  logic       d_minus_sync,
    input  logic       shift,
    input  logic       enable,
    input  logic       clear,
    output logic [7:0] rx_byte,
    output logic       byte_ready,
    output logic       stuff_bit,
    output logic       eop,
    output logic       stuff_err
);

    localparam int ONES_W = $clog2(ONES_LIMIT + 1);
    localparam logic [ONES_W-1:0] ONES_MAX  = ONES_W'(ONES_LIMIT);
    localparam logic [ONES_W-1:0] ONES_ZERO = ONES_W'(0);
    localparam logic [ONES_W-1:0] ONES_ONE  = ONES_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_STUFF = 3'd2,
        ST_SE0   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // NRZI: no transition on the line means a 1
    function automatic logic nrzi_bit(input logic dp, input logic prev_dp);
        return (dp == prev_dp);
    endfunction

    state_t            state_r,      state_s;
    logic              prev_dp_r,    prev_dp_s;
    logic [ONES_W-1:0] ones_cnt_r,   ones_cnt_s;
    logic [2:0]        bit_cnt_r,    bit_cnt_s;
    logic [7:0]        shreg_r,      shreg_s;
    logic [7:0]        rx_byte_r,    rx_byte_s;
    logic              byte_ready_r, byte_ready_s;
    logic              stuff_bit_r,  stuff_bit_s;
    logic              eop_r,        eop_s;
`ifdef RX_STUFF_ERR_EN
    logic              stuff_err_r,  stuff_err_s;
`endif

    logic              sample_s;
    logic              se0_s;
    logic              dec_bit_s;
    logic              take_data_s;
    logic [ONES_W-1:0] ones_inc_s;
    logic [7:0]        shreg_in_s;

    // Next-state and next-output logic for the decoder FSM and datapath
    always_comb begin
        sample_s     = shift & enable & ~clear;
        se0_s        = ~d_plus_sync & ~d_minus_sync;
        dec_bit_s    = nrzi_bit(d_plus_sync, prev_dp_r);
        // Saturate so a glitch-recovered 1 after a stuff slot cannot wrap
        ones_inc_s   = (ones_cnt_r == ONES_MAX) ? ONES_MAX : (ones_cnt_r + ONES_ONE);
        shreg_in_s   = {dec_bit_s, shreg_r[7:1]};

        state_s      = state_r;
        prev_dp_s    = prev_dp_r;
        ones_cnt_s   = ones_cnt_r;
        bit_cnt_s    = bit_cnt_r;
        shreg_s      = shreg_r;
        rx_byte_s    = rx_byte_r;
        byte_ready_s = 1'b0;
        stuff_bit_s  = 1'b0;
        eop_s        = 1'b0;
`ifdef RX_STUFF_ERR_EN
        stuff_err_s  = 1'b0;
`endif
        take_data_s  = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (enable) begin
                    state_s = ST_RECV;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RECV: begin
                if (sample_s && se0_s) begin
                    state_s = ST_SE0;
                end else if (sample_s) begin
                    take_data_s = 1'b1;
                end else begin
                    state_s = ST_RECV;
                end
            end
            ST_STUFF: begin
                if (sample_s && se0_s) begin
                    state_s = ST_SE0;
                end else if (sample_s) begin
                    // Stuffed bit: consumed for NRZI history only
                    prev_dp_s  = d_plus_sync;
                    ones_cnt_s = ONES_ZERO;
                    state_s    = ST_RECV;
`ifdef RX_STUFF_ERR_EN
                    stuff_err_s = dec_bit_s;
`endif
                end else begin
                    state_s = ST_STUFF;
                end
            end
            ST_SE0: begin
                if (sample_s && se0_s) begin
                    eop_s      = 1'b1;
                    bit_cnt_s  = 3'd0;
                    ones_cnt_s = ONES_ZERO;
                    shreg_s    = 8'h00;
                    state_s    = ST_DONE;
                end else if (sample_s) begin
                    // Lone SE0 was a glitch: this sample is ordinary data
                    take_data_s = 1'b1;
                end else begin
                    state_s = ST_SE0;
                end
            end
            ST_DONE: begin
                state_s = ST_DONE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        if (take_data_s) begin
            prev_dp_s = d_plus_sync;
            shreg_s   = shreg_in_s;
            if (bit_cnt_r == 3'd7) begin
                rx_byte_s    = shreg_in_s;
                byte_ready_s = 1'b1;
                bit_cnt_s    = 3'd0;
            end else begin
                bit_cnt_s = bit_cnt_r + 3'd1;
            end
            if (dec_bit_s && (ones_inc_s == ONES_MAX)) begin
                ones_cnt_s  = ones_inc_s;
                stuff_bit_s = 1'b1;
                state_s     = ST_STUFF;
            end else if (dec_bit_s) begin
                ones_cnt_s = ones_inc_s;
                state_s    = ST_RECV;
            end else begin
                ones_cnt_s = ONES_ZERO;
                state_s    = ST_RECV;
            end
        end else begin
            shreg_s = shreg_s;
        end

        // Restart/abort overrides everything except the held byte
        if (clear || !enable) begin
            state_s      = ST_IDLE;
            prev_dp_s    = 1'b1;
            ones_cnt_s   = ONES_ZERO;
            bit_cnt_s    = 3'd0;
            shreg_s      = 8'h00;
            rx_byte_s    = rx_byte_r;
            byte_ready_s = 1'b0;
            stuff_bit_s  = 1'b0;
            eop_s        = 1'b0;
`ifdef RX_STUFF_ERR_EN
            stuff_err_s  = 1'b0;
`endif
        end else begin
            rx_byte_s = rx_byte_s;
        end
    end

    // State, datapath and registered output flops
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r      <= ST_IDLE;
            prev_dp_r    <= 1'b1;
            ones_cnt_r   <= ONES_ZERO;
            bit_cnt_r    <= 3'd0;
            shreg_r      <= 8'h00;
            rx_byte_r    <= 8'h00;
            byte_ready_r <= 1'b0;
            stuff_bit_r  <= 1'b0;
            eop_r        <= 1'b0;
`ifdef RX_STUFF_ERR_EN
            stuff_err_r  <= 1'b0;
`endif
        end else begin
            state_r      <= state_s;
            prev_dp_r    <= prev_dp_s;
            ones_cnt_r   <= ones_cnt_s;
            bit_cnt_r    <= bit_cnt_s;
            shreg_r      <= shreg_s;
            rx_byte_r    <= rx_byte_s;
            byte_ready_r <= byte_ready_s;
            stuff_bit_r  <= stuff_bit_s;
            eop_r        <= eop_s;
`ifdef RX_STUFF_ERR_EN
            stuff_err_r  <= stuff_err_s;
`endif
        end
    end

    assign rx_byte    = rx_byte_r;
    assign byte_ready = byte_ready_r;
    assign stuff_bit  = stuff_bit_r;
    assign eop        = eop_r;
`ifdef RX_STUFF_ERR_EN
    assign stuff_err  = stuff_err_r;
`else
    assign stuff_err  = 1'b0;
`endif

endmodule
